// File: rtl/buzz_pattern_gen_if.sv
// Control/status bundle between the tick-driven pattern generator and its client.
// master drives the pattern request and reads status; slave is the generator.
interface buzz_pattern_gen_if #(
  parameter int TW = 8,
  parameter int NW = 4
);
  logic          i_tick;
  logic          i_go;
  logic          i_stop;
  logic          i_mode;
  logic [NW-1:0] i_beeps;
  logic [TW-1:0] i_on_ticks;
  logic [TW-1:0] i_off_ticks;
  logic          o_buzzer;
  logic          o_busy;
  logic          o_done;
  logic [NW-1:0] o_beep_idx;

  modport master (
    output i_tick, i_go, i_stop, i_mode, i_beeps, i_on_ticks, i_off_ticks,
    input  o_buzzer, o_busy, o_done, o_beep_idx
  );

  modport slave (
    input  i_tick, i_go, i_stop, i_mode, i_beeps, i_on_ticks, i_off_ticks,
    output o_buzzer, o_busy, o_done, o_beep_idx
  );
endinterface

// File: rtl/buzz_pattern_gen.sv
// Buzzer pattern generator: burst of N beeps or continuous train, on/off phases
// measured in ticks, optional square-wave tone during the on-phase.
module buzz_pattern_gen #(
  parameter int TW       = 8,
  parameter int NW       = 4,
  parameter int TONE_DIV = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  buzz_pattern_gen_if.slave bus
);

  localparam int TDW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TDW-1:0] TONE_LAST = TDW'((TONE_DIV > 0) ? TONE_DIV - 1 : 0);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  typedef struct packed {
    logic          mode;
    logic [NW-1:0] beeps;
    logic [TW-1:0] on_t;
    logic [TW-1:0] off_t;
  } cfg_t;

  state_t        state, state_nxt;
  cfg_t          cfg, cfg_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [NW-1:0] idx, idx_nxt;
  logic [TDW-1:0] tone_cnt, tone_cnt_nxt;
  logic          tone_lvl, tone_lvl_nxt;
  logic          done_nxt;
  logic          buz_q, busy_q, done_q;
  logic          go_ok, last_beep;

  // a mode-0 request for zero beeps is dropped entirely
  assign go_ok     = bus.i_go && (bus.i_mode || (bus.i_beeps != '0));
  assign last_beep = !cfg.mode && (idx == cfg.beeps - 1'b1);

  always_comb begin
    state_nxt    = state;
    cfg_nxt      = cfg;
    tcnt_nxt     = tcnt;
    idx_nxt      = idx;
    tone_cnt_nxt = tone_cnt;
    tone_lvl_nxt = tone_lvl;
    done_nxt     = 1'b0;
    if (bus.i_stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (go_ok) begin
          state_nxt     = ON;
          cfg_nxt.mode  = bus.i_mode;
          cfg_nxt.beeps = bus.i_beeps;
          cfg_nxt.on_t  = (bus.i_on_ticks  == '0) ? TW'(1) : bus.i_on_ticks;
          cfg_nxt.off_t = (bus.i_off_ticks == '0) ? TW'(1) : bus.i_off_ticks;
          tcnt_nxt      = '0;
          idx_nxt       = '0;
          tone_cnt_nxt  = '0;
          tone_lvl_nxt  = 1'b1;
        end
        ON: begin
          if (tone_cnt == TONE_LAST) begin
            tone_cnt_nxt = '0;
            tone_lvl_nxt = ~tone_lvl;
          end else begin
            tone_cnt_nxt = tone_cnt + 1'b1;
          end
          if (bus.i_tick) begin
            if (tcnt == cfg.on_t - 1'b1) begin
              tcnt_nxt = '0;
              if (last_beep) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
              end else begin
                state_nxt = OFF;
              end
            end else begin
              tcnt_nxt = tcnt + 1'b1;
            end
          end
        end
        OFF: if (bus.i_tick) begin
          if (tcnt == cfg.off_t - 1'b1) begin
            state_nxt    = ON;
            tcnt_nxt     = '0;
            idx_nxt      = idx + 1'b1;
            tone_cnt_nxt = '0;
            tone_lvl_nxt = 1'b1;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      cfg      <= '0;
      tcnt     <= '0;
      idx      <= '0;
      tone_cnt <= '0;
      tone_lvl <= 1'b0;
      buz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cfg      <= cfg_nxt;
      tcnt     <= tcnt_nxt;
      idx      <= idx_nxt;
      tone_cnt <= tone_cnt_nxt;
      tone_lvl <= tone_lvl_nxt;
      buz_q    <= (state_nxt == ON) && ((TONE_DIV == 0) || tone_lvl_nxt);
      busy_q   <= (state_nxt != IDLE);
      done_q   <= done_nxt;
    end
  end

  assign bus.o_buzzer   = buz_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_beep_idx = idx;

endmodule
